// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder: WIDTH/SEG stages, each resolving one SEG-bit segment built from BLK-bit select blocks.
// Optional subtract mode with signed overflow flag when CSEL_ADDER_PIPE_SUB_EN is defined.
module csel_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSEL_ADDER_PIPE_SUB_EN
  ,
  input  logic             sub,
  output logic             ovf
`endif
);

  localparam int NSEG = WIDTH / SEG;
  localparam int NBLK = SEG / BLK;

  if (WIDTH % SEG != 0) begin : g_bad_seg
    $error("csel_adder_pipe: WIDTH must be a multiple of SEG");
  end
  if (SEG % BLK != 0) begin : g_bad_blk
    $error("csel_adder_pipe: SEG must be a multiple of BLK");
  end

  // One segment: every block precomputes both carry cases, the block carries ripple through the select muxes.
  function automatic logic [SEG:0] csel_seg(input logic [SEG-1:0] x,
                                            input logic [SEG-1:0] y,
                                            input logic           ci);
    logic [SEG-1:0] s;
    logic           c;
    logic [BLK:0]   r0;
    logic [BLK:0]   r1;
    s = '0;
    c = ci;
    for (int i = 0; i < NBLK; i++) begin
      r0 = {1'b0, x[i*BLK +: BLK]} + {1'b0, y[i*BLK +: BLK]};
      r1 = {1'b0, x[i*BLK +: BLK]} + {1'b0, y[i*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
      s[i*BLK +: BLK] = c ? r1[BLK-1:0] : r0[BLK-1:0];
      c = c ? r1[BLK] : r0[BLK];
    end
    return {c, s};
  endfunction

  logic             adv;
  logic [WIDTH-1:0] b_in;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

`ifdef CSEL_ADDER_PIPE_SUB_EN
  assign b_in = sub ? ~b : b;
`else
  assign b_in = b;
`endif

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    // Operands still to be resolved arrive right-aligned, so the current segment is always the low SEG bits.
    localparam int IW = WIDTH - k*SEG;
    localparam int SW = (k+1)*SEG;

    logic [IW-1:0] a_i;
    logic [IW-1:0] b_i;
    logic          c_i;
    logic          vld_i;
    logic [SEG:0]  res;
    logic [SW-1:0] s_n;
    logic          vld_r;
    logic          c_r;
    logic [SW-1:0] s_r;

    assign res = csel_seg(a_i[SEG-1:0], b_i[SEG-1:0], c_i);

    if (k == 0) begin : g_head
      assign a_i   = a;
      assign b_i   = b_in;
      assign c_i   = cin;
      assign vld_i = in_valid;
      assign s_n   = res[SEG-1:0];
    end else begin : g_body
      assign a_i   = g_stage[k-1].g_ops.a_r;
      assign b_i   = g_stage[k-1].g_ops.b_r;
      assign c_i   = g_stage[k-1].c_r;
      assign vld_i = g_stage[k-1].vld_r;
      assign s_n   = {res[SEG-1:0], g_stage[k-1].s_r};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_r <= 1'b0;
        c_r   <= 1'b0;
        s_r   <= '0;
      end else if (adv) begin
        vld_r <= vld_i;
        c_r   <= res[SEG];
        s_r   <= s_n;
      end
    end

    if (k < NSEG-1) begin : g_ops
      logic [IW-SEG-1:0] a_r;
      logic [IW-SEG-1:0] b_r;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
        end else if (adv) begin
          a_r <= a_i[IW-1:SEG];
          b_r <= b_i[IW-1:SEG];
        end
      end
    end

`ifdef CSEL_ADDER_PIPE_SUB_EN
    // Signed overflow needs only the top segment: operand sign bits agree but the result sign differs.
    if (k == NSEG-1) begin : g_ovf
      logic ovf_r;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (adv) begin
          ovf_r <= (a_i[SEG-1] == b_i[SEG-1]) & (res[SEG-1] != a_i[SEG-1]);
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[NSEG-1].vld_r;
  assign sum       = g_stage[NSEG-1].s_r;
  assign cout      = g_stage[NSEG-1].c_r;
`ifdef CSEL_ADDER_PIPE_SUB_EN
  assign ovf       = g_stage[NSEG-1].g_ovf.ovf_r;
`endif

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Self-checking bench for csel_adder_pipe: directed corner cases plus randomized traffic against a queue-based arithmetic model.
module tb_csel_adder_pipe;

  localparam int W    = 32;
  localparam int NSEG = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         sub;
  logic         ovf;

  csel_adder_pipe #(.WIDTH(W), .SEG(8), .BLK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CSEL_ADDER_PIPE_SUB_EN
    ,
    .sub       (sub),
    .ovf       (ovf)
`endif
  );

`ifndef CSEL_ADDER_PIPE_SUB_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t         q[$];
  int           nvec = 0;
  int           nerr = 0;
  int           ncyc = 0;
  int           ndel = 0;
  int           first_del = -1;
  int           last_del = -1;
  logic         last_acc;
  logic         stalled_prev = 1'b0;
  logic [W-1:0] hold_s;
  logic         hold_c;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s);
    exp_t         e;
    logic [W-1:0] ye;
    logic [W:0]   t;
    longint       st;
    ye  = s ? ~y : y;
    t   = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, c};
    st  = longint'($signed(x)) + longint'($signed(ye)) + longint'(c);
    e.s = t[W-1:0];
    e.c = t[W];
    e.o = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    return e;
  endfunction

  // One clock: settle, check handshake/outputs against the model, update the model, advance.
  task automatic cycle();
    exp_t e;
    logic rdy_exp;
    #2;
    rdy_exp = out_ready | ~out_valid;
    chk("in_ready", {63'd0, in_ready}, {63'd0, rdy_exp});
    if (stalled_prev) begin
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_sum", {32'd0, sum}, {32'd0, hold_s});
      chk("hold_cout", {63'd0, cout}, {63'd0, hold_c});
    end
    if (out_valid === 1'b1) begin
      chk("no_stale_valid", {63'd0, (q.size() > 0)}, 64'd1);
      if (out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("sum", {32'd0, sum}, {32'd0, e.s});
        chk("cout", {63'd0, cout}, {63'd0, e.c});
`ifdef CSEL_ADDER_PIPE_SUB_EN
        chk("ovf", {63'd0, ovf}, {63'd0, e.o});
`endif
        ndel++;
        if (first_del < 0) first_del = ncyc;
        last_del = ncyc;
      end
    end
    stalled_prev = out_valid && !out_ready;
    hold_s = sum;
    hold_c = cout;
    last_acc = in_valid && in_ready;
    if (last_acc) q.push_back(model(a, b, cin, sub));
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic lat_test(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic s);
    a = x; b = y; cin = c; sub = s;
    in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (NSEG-1) begin
      chk("lat_early", {63'd0, out_valid}, 64'd0);
      cycle();
    end
    chk("lat_due", {63'd0, out_valid}, 64'd1);
    cycle();
    chk("lat_after", {63'd0, out_valid}, 64'd0);
    chk("lat_drained", 64'(q.size()), 64'd0);
  endtask

  task automatic drain();
    int g;
    g = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && g < 100) begin
      cycle();
      g++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic [W-1:0] bp_a [6];
    logic [W-1:0] bp_b [6];
    logic         bp_c [6];
    int           idx;
    int           stall_left;
    logic         started;
    int           g;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", {32'd0, sum}, 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed single adds and full carry propagation.
    lat_test(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    lat_test(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    lat_test(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    lat_test(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    lat_test(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 1'b0);

    // Streaming: 8 back-to-back operands.
    ndel = 0; first_del = -1; last_del = -1;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a = W'(i); b = W'(i); cin = 1'b0; in_valid = 1'b1;
      chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
      cycle();
    end
    drain();
    chk("stream_count", 64'(ndel), 64'd8);
    chk("stream_consecutive", 64'(last_del - first_del), 64'd7);

    // Backpressure: stall three cycles once the first result shows up.
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = $urandom; bp_b[i] = $urandom; bp_c[i] = 1'($urandom_range(0, 1));
    end
    idx = 0; stall_left = 3; started = 1'b0; g = 0; ndel = 0;
    while ((idx < 6 || q.size() > 0) && g < 100) begin
      in_valid = (idx < 6);
      if (idx < 6) begin a = bp_a[idx]; b = bp_b[idx]; cin = bp_c[idx]; end
      if (out_valid) started = 1'b1;
      if (started && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      cycle();
      if (last_acc) idx++;
      g++;
    end
    chk("bp_all_delivered", 64'(ndel), 64'd6);
    chk("bp_stall_seen", 64'(stall_left), 64'd0);

    // Reset while three operands are in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; cin = 1'b1; in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_sum", {32'd0, sum}, 64'd0);
    chk("midrst_cout", {63'd0, cout}, 64'd0);
    q.delete();
    stalled_prev = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) begin
      chk("midrst_no_stale", {63'd0, out_valid}, 64'd0);
      cycle();
    end
    lat_test(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);

`ifdef CSEL_ADDER_PIPE_SUB_EN
    lat_test(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    lat_test(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1);
    lat_test(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
`endif

    // Randomized traffic with random backpressure and corner operands.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       begin a = '1; b = $urandom; end
        1:       begin a = $urandom; b = ~a; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      cin = 1'($urandom_range(0, 1));
`ifdef CSEL_ADDER_PIPE_SUB_EN
      sub = 1'($urandom_range(0, 1));
`endif
      cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
